mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_sat_counter.sv | 24 ++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D cacheline memory arbiter.
// Holds FSM state and grant encodings plus counter limits.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

    localparam int          CNT_W   = 32;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// 32-bit saturating event counter.
// Ports: clk, rst (async active-low), inc, count.
module sat_counter
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-side and D-side cacheline requests onto one memory port.
// Ports: imem_* / dmem_* requesters, mem_* shared port, i/d_grants counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_read,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic [LINE_W-1:0] imem_rdata,
    output logic              imem_resp,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [LINE_W-1:0] dmem_wdata,
    output logic [LINE_W-1:0] dmem_rdata,
    output logic              dmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [31:0]       i_grants,
    output logic [31:0]       d_grants
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    grant_t            last_grant;
    grant_t            grant_sel;
    logic              grant_en;
    logic              i_pend;
    logic              d_pend;
    logic              busy;
    logic              out_rd;
    logic              out_wr;
    logic [ADDR_W-1:0] out_addr;
    logic [LINE_W-1:0] out_wdata;

    assign i_pend = imem_read;
    assign d_pend = dmem_read | dmem_write;

    always_comb begin
        state_d   = state_q;
        grant_en  = 1'b0;
        grant_sel = GRANT_I;
        unique case (state_q)
            IDLE: begin
                if (i_pend && d_pend) begin
                    // Round-robin on contention: alternate from last owner.
                    grant_en  = 1'b1;
                    grant_sel = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
                end else if (i_pend) begin
                    grant_en  = 1'b1;
                    grant_sel = GRANT_I;
                end else if (d_pend) begin
                    grant_en  = 1'b1;
                    grant_sel = GRANT_D;
                end
                if (grant_en) begin
                    state_d = (grant_sel == GRANT_I) ? I_BUSY : D_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outstanding request is captured once at grant and held for the
    // whole transaction, so requester changes mid-flight are invisible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= GRANT_D;
            out_rd     <= 1'b0;
            out_wr     <= 1'b0;
            out_addr   <= '0;
            out_wdata  <= '0;
        end else if (grant_en) begin
            last_grant <= grant_sel;
            if (grant_sel == GRANT_I) begin
                out_rd    <= 1'b1;
                out_wr    <= 1'b0;
                out_addr  <= imem_addr;
                out_wdata <= '0;
            end else begin
                // Simultaneous read+write from D is a write.
                out_rd    <= ~dmem_write;
                out_wr    <= dmem_write;
                out_addr  <= dmem_addr;
                out_wdata <= dmem_wdata;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign mem_read  = busy & out_rd;
    assign mem_write = busy & out_wr;
    assign mem_addr  = out_addr;
    assign mem_wdata = out_wdata;

    assign imem_resp  = (state_q == I_BUSY) & mem_resp;
    assign dmem_resp  = (state_q == D_BUSY) & mem_resp;
    assign imem_rdata = imem_resp ? mem_rdata : '0;
    assign dmem_rdata = dmem_resp ? mem_rdata : '0;

    sat_counter u_i_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (imem_resp),
        .count (i_grants)
    );

    sat_counter u_d_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (dmem_resp),
        .count (d_grants)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Drives inputs on negedge, checks #1 later.
module tb_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         imem_read;
    logic [31:0]  imem_addr;
    logic [255:0] imem_rdata;
    logic         imem_resp;
    logic         dmem_read;
    logic         dmem_write;
    logic [31:0]  dmem_addr;
    logic [255:0] dmem_wdata;
    logic [255:0] dmem_rdata;
    logic         dmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic [31:0]  i_grants;
    logic [31:0]  d_grants;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_read  (imem_read),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .i_grants   (i_grants),
        .d_grants   (d_grants)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    localparam logic [255:0] L1 = {8{32'hA5A5_0001}};
    localparam logic [255:0] L2 = {8{32'h1234_5678}};
    localparam logic [255:0] L3 = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] W1 = {8{32'hCAFE_F00D}};

    initial begin
        rst        = 1'b0;
        imem_read  = 1'b0;
        imem_addr  = '0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        mem_rdata  = '0;
        mem_resp   = 1'b0;

        // Reset state
        cyc();
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_i_grants", i_grants, 0);
        chk("rst_d_grants", d_grants, 0);
        cyc();
        rst = 1'b1;

        // Single I read, resp on cycle 3
        cyc();
        imem_read = 1'b1;
        imem_addr = 32'h4000_0000;
        #1;
        chk("i_c0_mem_read", mem_read, 0);
        cyc();
        #1;
        chk("i_c1_mem_read", mem_read, 1);
        chk("i_c1_mem_addr", mem_addr, 32'h4000_0000);
        chk("i_c1_imem_resp", imem_resp, 0);
        chk("i_c1_imem_rdata", imem_rdata, 0);
        cyc();
        #1;
        chk("i_c2_mem_read", mem_read, 1);
        cyc();
        mem_resp  = 1'b1;
        mem_rdata = L1;
        #1;
        chk("i_c3_mem_read", mem_read, 1);
        chk("i_c3_imem_resp", imem_resp, 1);
        chk("i_c3_imem_rdata", imem_rdata, L1);
        chk("i_c3_dmem_resp", dmem_resp, 0);
        chk("i_c3_dmem_rdata", dmem_rdata, 0);
        cyc();
        mem_resp  = 1'b0;
        imem_read = 1'b0;
        #1;
        chk("i_c4_mem_read", mem_read, 0);
        chk("i_c4_i_grants", i_grants, 1);

        // Contention after reset: I first, then D write (read+write => write)
        do_reset();
        imem_read  = 1'b1;
        imem_addr  = 32'h0000_1000;
        dmem_read  = 1'b1;
        dmem_write = 1'b1;
        dmem_addr  = 32'h0000_2000;
        dmem_wdata = W1;
        cyc();
        #1;
        chk("c_i_mem_read", mem_read, 1);
        chk("c_i_mem_write", mem_write, 0);
        chk("c_i_mem_addr", mem_addr, 32'h0000_1000);
        mem_resp  = 1'b1;
        mem_rdata = L2;
        #1;
        chk("c_i_imem_resp", imem_resp, 1);
        chk("c_i_dmem_resp", dmem_resp, 0);
        chk("c_i_dmem_rdata", dmem_rdata, 0);
        cyc();
        mem_resp  = 1'b0;
        imem_read = 1'b0;
        #1;
        chk("c_gap_mem_read", mem_read, 0);
        chk("c_gap_mem_write", mem_write, 0);
        chk("c_gap_i_grants", i_grants, 1);
        cyc();
        #1;
        chk("c_d_mem_write", mem_write, 1);
        chk("c_d_mem_read", mem_read, 0);
        chk("c_d_mem_addr", mem_addr, 32'h0000_2000);
        chk("c_d_mem_wdata", mem_wdata, W1);
        mem_resp = 1'b1;
        #1;
        chk("c_d_dmem_resp", dmem_resp, 1);
        chk("c_d_imem_resp", imem_resp, 0);
        cyc();
        mem_resp   = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        #1;
        chk("c_d_grants", d_grants, 1);
        chk("c_d_idle_write", mem_write, 0);

        // Both held for 4 transactions: I, D, I, D
        imem_addr = 32'h0000_3000;
        dmem_addr = 32'h0000_4000;
        imem_read = 1'b1;
        dmem_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            chk("rr_mem_read", mem_read, 1);
            chk("rr_mem_addr", mem_addr,
                (k % 2 == 0) ? 32'h0000_3000 : 32'h0000_4000);
            mem_resp  = 1'b1;
            mem_rdata = L3;
            #1;
            chk("rr_imem_resp", imem_resp, (k % 2 == 0) ? 1 : 0);
            chk("rr_dmem_resp", dmem_resp, (k % 2 == 0) ? 0 : 1);
            cyc();
            mem_resp = 1'b0;
            if (k == 3) begin
                imem_read = 1'b0;
                dmem_read = 1'b0;
            end
            #1;
            chk("rr_gap_mem_read", mem_read, 0);
        end
        chk("rr_i_grants", i_grants, 3);
        chk("rr_d_grants", d_grants, 3);

        // D address changes mid-transaction
        dmem_read = 1'b1;
        dmem_addr = 32'h0000_5000;
        cyc();
        #1;
        chk("mid_c1_addr", mem_addr, 32'h0000_5000);
        dmem_addr  = 32'h0000_6000;
        dmem_wdata = L1;
        cyc();
        #1;
        chk("mid_c2_addr", mem_addr, 32'h0000_5000);
        cyc();
        mem_resp = 1'b1;
        #1;
        chk("mid_c3_addr", mem_addr, 32'h0000_5000);
        chk("mid_c3_dmem_resp", dmem_resp, 1);
        cyc();
        mem_resp  = 1'b0;
        dmem_read = 1'b0;
        #1;
        chk("mid_d_grants", d_grants, 4);

        // Reset during I_BUSY, then stray mem_resp in IDLE
        imem_read = 1'b1;
        imem_addr = 32'h0000_7000;
        cyc();
        #1;
        chk("rb_busy_read", mem_read, 1);
        rst = 1'b0;
        #1;
        chk("rb_rst_mem_read", mem_read, 0);
        chk("rb_rst_mem_addr", mem_addr, 0);
        chk("rb_rst_i_grants", i_grants, 0);
        imem_read = 1'b0;
        cyc();
        rst      = 1'b1;
        mem_resp = 1'b1;
        #1;
        chk("rb_idle_imem_resp", imem_resp, 0);
        chk("rb_idle_imem_rdata", imem_rdata, 0);
        cyc();
        mem_resp = 1'b0;
        #1;
        chk("rb_i_grants", i_grants, 0);
        chk("rb_mem_read", mem_read, 0);

        // Saturation of d_grants
        force dut.u_d_cnt.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_d_cnt.count_q;
        #1;
        chk("sat_preload", d_grants, 32'hFFFF_FFFE);
        for (int k = 0; k < 2; k++) begin
            cyc();
            dmem_read = 1'b1;
            cyc();
            mem_resp = 1'b1;
            #1;
            chk("sat_dmem_resp", dmem_resp, 1);
            cyc();
            mem_resp  = 1'b0;
            dmem_read = 1'b0;
            #1;
            chk("sat_d_grants", d_grants, 32'hFFFF_FFFF);
        end
        cyc();
        #1;
        chk("sat_hold", d_grants, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
